ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver for keyboard/mouse ports. It adds four things to the basic PS/2 byte receiver:
- a glitch filter on PS2C;
- full 11-bit frame checking (start, odd parity, stop);
- an inter-bit timeout that resynchronises a broken frame;
- a FIFO of configurable depth with occupancy count and sticky error and overflow flags.

It sits between the PS/2 pins and the CPU I/O register interface. The read side keeps the existing rdy/done/data handshake.

---
 rtl/ps2_rx_fifo_if.sv | 27 ++
 rtl/ps2_rx_fifo.sv | 130 +++++++++++++
 tb/tb_ps2_rx_fifo.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// Pin and CPU-side signal bundle for the PS/2 receiver with FIFO.
// The receiver takes the slave view; the host/bench drives through master.
interface ps2_rx_fifo_if #(
  parameter int AW = 4
);
  logic          PS2C;
  logic          PS2D;
  logic          done;
  logic          clr_err;
  logic          rdy;
  logic [7:0]    data;
  logic          shift;
  logic [AW:0]   count;
  logic          perr;
  logic          ferr;
  logic          ovf;

  modport slave (
    input  PS2C, PS2D, done, clr_err,
    output rdy, data, shift, count, perr, ferr, ovf
  );

  modport master (
    output PS2C, PS2D, done, clr_err,
    input  rdy, data, shift, count, perr, ferr, ovf
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: glitch-filtered clock, 11-bit frame check,
// inter-bit timeout and a byte FIFO with sticky error/overflow flags.
module ps2_rx_fifo #(
  parameter int AW      = 4,
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
) (
  input logic          clk,
  input logic          rst,
  ps2_rx_fifo_if.slave bus
);
  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  function automatic logic framing_ok(input logic start_bit, input logic stop_bit);
    return ~start_bit & stop_bit;
  endfunction

  logic          ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;
  logic [FW-1:0] filt_cnt;
  logic          ps2c_f;
  logic          shift_r;
  logic [3:0]    bitcnt;
  logic [9:0]    frame;
  logic [TW-1:0] to_cnt;
  logic          perr_r, ferr_r, ovf_r;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [2**AW];

  logic [AW:0] count;
  logic        rdy, full, pop, fall, eval, frm_ok, par_ok, push, drop, timeout;

  always_comb begin
    count   = wr_ptr - rd_ptr;
    rdy     = (count != '0);
    full    = (count == {1'b1, {AW{1'b0}}});
    pop     = bus.done & rdy;
    fall    = ps2c_f & ~ps2c_p1 & (filt_cnt == FW'(FILT - 1));
    eval    = shift_r & (bitcnt == 4'd10);
    // frame[0] is the start bit, frame[8:1] data, frame[9] parity; stop is live
    frm_ok  = framing_ok(frame[0], ps2d_p1);
    par_ok  = odd_parity_ok(frame[9:1]);
    push    = eval & frm_ok & par_ok & (~full | pop);
    drop    = eval & frm_ok & par_ok & full & ~pop;
    timeout = ~shift_r & (bitcnt != 4'd0) & (to_cnt == TW'(TIMEOUT - 1));
  end

  // Stage p0/p1: two-flop synchronisers, then the persistence filter
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2c_p0  <= 1'b1;
      ps2c_p1  <= 1'b1;
      ps2d_p0  <= 1'b1;
      ps2d_p1  <= 1'b1;
      filt_cnt <= '0;
      ps2c_f   <= 1'b1;
      shift_r  <= 1'b0;
    end else begin
      ps2c_p0 <= bus.PS2C;
      ps2c_p1 <= ps2c_p0;
      ps2d_p0 <= bus.PS2D;
      ps2d_p1 <= ps2d_p0;
      shift_r <= fall;
      if (ps2c_p1 == ps2c_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT - 1)) begin
        filt_cnt <= '0;
        ps2c_f   <= ps2c_p1;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame capture: shift in LSB-first so the start bit lands in frame[0]
  always_ff @(posedge clk) begin
    if (shift_r) frame <= {ps2d_p1, frame[9:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt <= '0;
      to_cnt <= '0;
    end else begin
      if (shift_r) bitcnt <= (bitcnt == 4'd10) ? 4'd0 : bitcnt + 4'd1;
      else if (timeout) bitcnt <= '0;
      if (shift_r || bitcnt == 4'd0 || timeout) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as clr_err wins
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      perr_r <= (perr_r & ~bus.clr_err) | (eval & frm_ok & ~par_ok);
      ferr_r <= (ferr_r & ~bus.clr_err) | (eval & ~frm_ok) | timeout;
      ovf_r  <= (ovf_r & ~bus.clr_err) | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= frame[8:1];
  end

  assign bus.rdy   = rdy;
  assign bus.data  = rdy ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign bus.shift = shift_r;
  assign bus.count = count;
  assign bus.perr  = perr_r;
  assign bus.ferr  = ferr_r;
  assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames in, scoreboard
// queue of expected bytes checked by a monitor on every FIFO pop.
module tb_ps2_rx_fifo;
  localparam int AW      = 2;
  localparam int FILT    = 8;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_rx_fifo_if #(.AW(AW)) bus ();

  ps2_rx_fifo #(.AW(AW), .FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         shift_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next posedge whenever done & rdy
  always @(negedge clk) begin
    if (bus.shift) shift_cnt++;
    if (!rst && bus.done && bus.rdy) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got %0h, expected no byte", bus.data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.data !== mon_exp) begin
          n_fail++;
          $display("FAIL pop_data: got %0h, expected %0h", bus.data, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic glitch, input logic pop_eval);
    bus.PS2D = b;
    if (glitch) begin
      tick(8);
      bus.PS2C = 1'b0;
      tick(3);
      bus.PS2C = 1'b1;
      tick(HALF - 11);
    end else begin
      tick(HALF);
    end
    bus.PS2C = 1'b0;
    for (int k = 0; k < HALF; k++) begin
      tick(1);
      if (pop_eval && bus.shift) begin
        bus.done = 1'b1;
        tick(1);
        bus.done = 1'b0;
        k++;
      end
    end
    bus.PS2C = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input logic pop_eval, input int glitch_bit, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_bit, pop_eval && i == 10);
    bus.PS2D = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic good(input logic [7:0] d);
    exp_q.push_back(d);
    send_frame(d, 1'b0, 1'b0, 1'b0, -1, 11);
  endtask

  task automatic read_byte();
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    tick(1);
  endtask

  task automatic clear_flags();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.PS2C = 1'b1;
    bus.PS2D = 1'b1;
    bus.done = 1'b0;
    bus.clr_err = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("reset_outputs", {bus.rdy, bus.data, bus.shift, bus.count, bus.perr, bus.ferr, bus.ovf}, 0);
    rst = 1'b0;
    tick(2);

    // Basic make code
    shift_cnt = 0;
    good(8'h1C);
    chk("shift_count_1C", shift_cnt, 11);
    chk("rdy_1C", bus.rdy, 1);
    chk("data_1C", bus.data, 8'h1C);
    chk("count_1C", bus.count, 1);
    chk("flags_1C", {bus.perr, bus.ferr, bus.ovf}, 3'b000);
    read_byte();
    chk("empty_after_read", {bus.rdy, bus.data, bus.count}, 0);

    // Parity and stop errors
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, -1, 11);
    chk("perr_set", {bus.perr, bus.ferr, bus.ovf}, 3'b100);
    chk("perr_no_push", {bus.rdy, bus.count}, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, -1, 11);
    chk("ferr_stop", {bus.perr, bus.ferr, bus.ovf}, 3'b110);
    chk("ferr_no_push", bus.count, 0);
    clear_flags();
    chk("clr_err", {bus.perr, bus.ferr, bus.ovf}, 3'b000);

    // Overflow with depth 4
    good(8'h11); good(8'h22); good(8'h33); good(8'h44);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, 11);
    chk("count_full", bus.count, 4);
    chk("ovf_set", {bus.perr, bus.ferr, bus.ovf}, 3'b001);
    repeat (4) read_byte();
    chk("drained", {bus.rdy, bus.count}, 0);
    clear_flags();

    // Push while full with a pop on the evaluation cycle
    good(8'h11); good(8'h22); good(8'h33); good(8'h44);
    chk("count_full2", bus.count, 4);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 11);
    chk("no_ovf_with_pop", bus.ovf, 0);
    chk("count_stays_4", bus.count, 4);
    repeat (4) read_byte();
    chk("drained2", {bus.rdy, bus.count}, 0);

    // Inter-bit timeout
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1, 5);
    tick(TIMEOUT + 10);
    chk("timeout_ferr", {bus.perr, bus.ferr, bus.ovf}, 3'b010);
    chk("timeout_no_push", {bus.rdy, bus.count}, 0);
    clear_flags();
    good(8'hF0);
    chk("data_F0", bus.data, 8'hF0);
    chk("count_F0", bus.count, 1);
    chk("flags_F0", {bus.perr, bus.ferr, bus.ovf}, 3'b000);
    read_byte();

    // Short glitch mid-frame is filtered out
    shift_cnt = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 5, 11);
    chk("glitch_shift_count", shift_cnt, 11);
    chk("glitch_data", bus.data, 8'hA5);
    chk("glitch_flags", {bus.perr, bus.ferr, bus.ovf}, 3'b000);
    read_byte();

    // A low pulse one cycle longer than FILT gives exactly one shift
    shift_cnt = 0;
    bus.PS2C = 1'b0;
    tick(FILT + 1);
    bus.PS2C = 1'b1;
    tick(30);
    chk("long_pulse_one_shift", shift_cnt, 1);
    tick(TIMEOUT + 10);
    chk("long_pulse_timeout", {bus.ferr, bus.count}, {1'b1, 3'd0});
    clear_flags();

    // Reset mid-frame
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, -1, 6);
    rst = 1'b1;
    tick(1);
    chk("reset_midframe", {bus.rdy, bus.data, bus.shift, bus.count, bus.perr, bus.ferr, bus.ovf}, 0);
    rst = 1'b0;
    tick(2);

    // Reset with bytes queued and a flag set
    good(8'h01); good(8'h02); good(8'h03);
    send_frame(8'h04, 1'b1, 1'b0, 1'b0, -1, 11);
    chk("count_3_perr", {bus.count, bus.perr}, {3'd3, 1'b1});
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    chk("reset_with_data", {bus.rdy, bus.data, bus.shift, bus.count, bus.perr, bus.ferr, bus.ovf}, 0);
    rst = 1'b0;
    tick(2);

    good(8'h5A);
    chk("count_5A", bus.count, 1);
    chk("data_5A", bus.data, 8'h5A);
    chk("flags_5A", {bus.perr, bus.ferr, bus.ovf}, 3'b000);
    read_byte();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
